// File: rtl/booth_r4_seq_mul_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
// Digit selects encode {negate, double, single} so the datapath can decode them bitwise.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] SEL_ZERO = 3'b000;
  localparam logic [2:0] SEL_P1   = 3'b001;
  localparam logic [2:0] SEL_P2   = 3'b010;
  localparam logic [2:0] SEL_N1   = 3'b101;
  localparam logic [2:0] SEL_N2   = 3'b110;

  // Operands are extended by two bits, so there is one more digit than WIDTH/2.
  function automatic int booth_iters(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_seq_mul_if.sv
// Operand/result handshake bundle for booth_r4_seq_mul.
// Both sides use valid/ready; a transfer happens on a clock edge where both are high.
interface booth_r4_seq_mul_if #(
  parameter int WIDTH = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] final_result;

  modport master (
    output in_valid, multiplicand, multiplier, signed_mode, out_ready,
    input  in_ready, out_valid, final_result
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, signed_mode, out_ready,
    output in_ready, out_valid, final_result
  );

endinterface

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b2i+1, b2i, b2i-1} to a digit select.
// Purely combinational.
module booth_r4_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0] win_i,
  output logic [2:0] sel_o
);

  always_comb begin
    sel_o = SEL_ZERO;
    unique case (win_i)
      3'b001, 3'b010: sel_o = SEL_P1;
      3'b011:         sel_o = SEL_P2;
      3'b100:         sel_o = SEL_N2;
      3'b101, 3'b110: sel_o = SEL_N1;
      default:        sel_o = SEL_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier, one digit per clock; result valid WIDTH/2+1 edges after accept.
// Accepts only in IDLE; the result and out_valid hold indefinitely while out_ready is low.
module booth_r4_seq_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  booth_r4_seq_mul_if.slave  bus
);

  localparam int EXT_W = WIDTH + 2;
  localparam int ACC_W = 2 * EXT_W;
  localparam int SUM_W = ACC_W + 2;
  localparam int ITERS = booth_iters(WIDTH);
  localparam int CNT_W = $clog2(ITERS + 1);

  generate
    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("booth_r4_seq_mul: WIDTH must be even and at least 4");
    end
  endgenerate

  state_e               state_q, state_d;
  logic [EXT_W-1:0]     mcand_q, mcand_d;
  logic [EXT_W-1:0]     mplr_q, mplr_d;
  logic                 prev_q, prev_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [2:0]           sel;
  logic [EXT_W:0]       mag;
  logic [EXT_W:0]       pp;
  logic [SUM_W-1:0]     addend;
  logic [SUM_W-1:0]     cin_vec;
  logic [SUM_W-1:0]     sum;
  logic [ACC_W-1:0]     acc_step;

  booth_r4_digit_enc u_enc (
    .win_i ({mplr_q[1:0], prev_q}),
    .sel_o (sel)
  );

  // The digit is added at weight 2^EXT_W and everything shifts right by 2 each step;
  // after ITERS steps the accumulated shift equals 2^EXT_W, leaving the exact product.
  always_comb begin
    mag     = '0;
    pp      = '0;
    addend  = '0;
    cin_vec = '0;
    if (sel != SEL_ZERO) begin
      mag = sel[1] ? {mcand_q, 1'b0} : {mcand_q[EXT_W-1], mcand_q};
    end
    pp               = sel[2] ? ~mag : mag;
    addend           = {pp[EXT_W], pp, {EXT_W{1'b0}}};
    cin_vec[EXT_W]   = sel[2];
    sum              = {{2{acc_q[ACC_W-1]}}, acc_q} + addend + cin_vec;
    acc_step         = ACC_W'($signed(sum) >>> 2);
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    prev_d   = prev_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d = {{2{bus.signed_mode & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
          mplr_d  = {{2{bus.signed_mode & bus.multiplier[WIDTH-1]}}, bus.multiplier};
          prev_d  = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_step;
        mplr_d = mplr_q >> 2;
        prev_d = mplr_q[1];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          result_d = acc_step[2*WIDTH-1:0];
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplr_q   <= '0;
      prev_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      prev_q   <= prev_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.final_result = result_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Bench for booth_r4_seq_mul at WIDTH=8 and WIDTH=4 with directed vectors and a result scoreboard.
module tb_booth_r4_seq_mul;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  logic [15:0] q8[$];
  logic [7:0]  q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_r4_seq_mul_if #(.WIDTH(8)) b8();
  booth_r4_seq_mul_if #(.WIDTH(4)) b4();

  booth_r4_seq_mul #(.WIDTH(8)) u_dut8 (.CLK(clk), .RST(rst), .bus(b8.slave));
  booth_r4_seq_mul #(.WIDTH(4)) u_dut4 (.CLK(clk), .RST(rst), .bus(b4.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitors: every result handshake must match the oldest expected value.
  always @(negedge clk) begin
    if (!rst && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) begin
        n_total++;
        $display("FAIL res8_unexpected: got 0x%0h with no result pending", b8.final_result);
      end else begin
        chk("res8", b8.final_result, q8.pop_front());
      end
    end
    if (!rst && b4.out_valid && b4.out_ready) begin
      if (q4.size() == 0) begin
        n_total++;
        $display("FAIL res4_unexpected: got 0x%0h with no result pending", b4.final_result);
      end else begin
        chk("res4", b4.final_result, q4.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at accept edge+1 with the cycle number of the accept.
  task automatic issue(input bit is4, input logic [7:0] a, input logic [7:0] b, input bit sm,
                       input logic [15:0] exp, input bit push, output int acc_cyc);
    int waited = 0;
    while (!(is4 ? b4.in_ready : b8.in_ready) && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 40) begin
      n_total++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
    end
    if (is4) begin
      b4.in_valid = 1'b1; b4.multiplicand = a[3:0]; b4.multiplier = b[3:0]; b4.signed_mode = sm;
      if (push) q4.push_back(exp[7:0]);
    end else begin
      b8.in_valid = 1'b1; b8.multiplicand = a; b8.multiplier = b; b8.signed_mode = sm;
      if (push) q8.push_back(exp);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    b4.in_valid = 1'b0;
    b8.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit is4, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(is4 ? b4.out_valid : b8.out_valid) && lat < 30);
  endtask

  initial begin
    int a0, a1, lat, waited;
    rst = 1'b1;
    b8.in_valid = 1'b0; b8.multiplicand = '0; b8.multiplier = '0; b8.signed_mode = 1'b0; b8.out_ready = 1'b1;
    b4.in_valid = 1'b0; b4.multiplicand = '0; b4.multiplier = '0; b4.signed_mode = 1'b0; b4.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst8_out_valid", b8.out_valid, 0);
    chk("rst8_in_ready", b8.in_ready, 1);
    chk("rst8_final", b8.final_result, 0);
    chk("rst4_out_valid", b4.out_valid, 0);
    chk("rst4_in_ready", b4.in_ready, 1);
    chk("rst4_final", b4.final_result, 0);

    issue(0, 8'h07, 8'hFD, 1, 16'hFFEB, 1, a0);
    wait_valid(0, lat);
    chk("lat8_7xm3", lat, 5);

    issue(0, 8'h80, 8'h80, 1, 16'h4000, 1, a0);
    issue(0, 8'h80, 8'h7F, 1, 16'hC080, 1, a0);

    issue(0, 8'hFF, 8'hFF, 0, 16'hFE01, 1, a0);
    issue(0, 8'hFF, 8'hFF, 1, 16'h0001, 1, a1);
    chk("init_interval", a1 - a0, 7);

    issue(0, 8'h00, 8'h5A, 1, 16'h0000, 1, a0);
    wait_valid(0, lat);
    chk("lat8_zero", lat, 5);

    // Backpressure: result must sit still and a stray in_valid must be ignored.
    issue(0, 8'h80, 8'h7F, 1, 16'hC080, 1, a0);
    b8.out_ready = 1'b0;
    wait_valid(0, lat);
    chk("lat8_bp", lat, 5);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", b8.out_valid, 1);
      chk("bp_final", b8.final_result, 16'hC080);
      chk("bp_in_ready", b8.in_ready, 0);
      if (i == 3) begin
        b8.in_valid = 1'b1; b8.multiplicand = 8'd5; b8.multiplier = 8'd5; b8.signed_mode = 1'b1;
      end else begin
        b8.in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b1;
    chk("release_in_ready_same", b8.in_ready, 0);
    @(posedge clk); #1;
    chk("release_in_ready_next", b8.in_ready, 1);
    chk("release_out_valid", b8.out_valid, 0);

    // Reset two cycles into a calculation abandons it.
    issue(0, 8'd100, 8'd100, 0, 16'h0000, 0, a0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", b8.out_valid, 0);
    chk("midrst_in_ready", b8.in_ready, 1);
    chk("midrst_final", b8.final_result, 0);
    repeat (10) begin @(posedge clk); #1; end
    chk("midrst_no_result", b8.out_valid, 0);
    issue(0, 8'd3, 8'd4, 0, 16'h000C, 1, a0);
    wait_valid(0, lat);
    chk("lat8_3x4", lat, 5);

    issue(1, 8'h08, 8'h08, 1, 16'h0040, 1, a0);
    wait_valid(1, lat);
    chk("lat4_m8xm8", lat, 3);
    issue(1, 8'h0F, 8'h0F, 0, 16'h00E1, 1, a0);
    issue(1, 8'h07, 8'h08, 1, 16'h00C8, 1, a0);

    waited = 0;
    while ((q8.size() != 0 || q4.size() != 0) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
